execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 104 ++++++++++
 tb/tb_execute_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with ALU, branch target, iterative MULT and EX/MEM register
module execute_stage #(
    parameter int MULT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] pcAdded,
    input  logic [31:0] read1,
    input  logic [31:0] read2,
    input  logic [31:0] imm,
    input  logic [4:0]  i20_16,
    input  logic [4:0]  i15_11,
    input  logic        regDst,
    input  logic        aluSrc,
    input  logic [2:0]  aluOp,
    input  logic        branch,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic        jump,
    output logic        stall,
    output logic [31:0] outBranchTarget,
    output logic        outZero,
    output logic [31:0] outAluResult,
    output logic [31:0] outRead2,
    output logic [4:0]  outWriteReg,
    output logic        outBranch,
    output logic        outMemWrite,
    output logic        outMemRead,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        outJump
);
    localparam int CW = $clog2(MULT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, nextState;
    logic [CW-1:0] count;
    logic [31:0] mcand, mplier, acc, opB, aluResult, result;
    logic [2:0] fn;
    logic isMult, capture;
    always_comb begin
        opB = aluSrc ? imm : read2;
        fn = aluOp != 3'b010 ? aluOp :
             imm[5:0] == 6'b100000 ? 3'b000 :
             imm[5:0] == 6'b100010 ? 3'b001 :
             imm[5:0] == 6'b100100 ? 3'b011 :
             imm[5:0] == 6'b100101 ? 3'b100 :
             imm[5:0] == 6'b101010 ? 3'b101 : 3'b010;
        aluResult = fn == 3'b001 ? read1 - opB :
                    fn == 3'b011 ? read1 & opB :
                    fn == 3'b100 ? read1 | opB :
                    fn == 3'b101 ? {31'd0, $signed(read1) < $signed(opB)} :
                    fn == 3'b010 ? 32'd0 : read1 + opB;
        isMult = aluOp == 3'b010 && imm[5:0] == 6'b011000;
        nextState = flush ? IDLE :
                    state == IDLE ? (isMult ? BUSY : IDLE) :
                    state == BUSY ? (count == CW'(MULT_CYCLES - 1) ? DONE : BUSY) : IDLE;
        stall = !reset && !flush && ((state == IDLE && isMult) || state == BUSY);
        capture = !flush && ((state == IDLE && !isMult) || state == DONE);
        result = state == DONE ? acc : aluResult;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            outBranchTarget <= '0;
            outZero <= 1'b0;
            outAluResult <= '0;
            outRead2 <= '0;
            outWriteReg <= '0;
            {outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, outJump} <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && isMult && !flush) begin
                mcand <= read1;
                mplier <= read2;
                acc <= '0;
                count <= '0;
            end else if (state == BUSY) begin
                acc <= mplier[0] ? acc + mcand : acc;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                count <= count + CW'(1);
            end
            // bubbles clear only the control bits; data outputs hold their last value
            if (capture) begin
                outBranchTarget <= pcAdded + {imm[29:0], 2'b00};
                outZero <= result == 32'd0;
                outAluResult <= result;
                outRead2 <= read2;
                outWriteReg <= regDst ? i15_11 : i20_16;
                {outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, outJump} <=
                    {branch, memWrite, memRead, regWrite, memToReg, jump};
            end else begin
                {outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, outJump} <= '0;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage with directed vectors
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] pcAdded, read1, read2, imm;
    logic [4:0]  i20_16, i15_11;
    logic        regDst, aluSrc;
    logic [2:0]  aluOp;
    logic        branch, memWrite, memRead, regWrite, memToReg, jump;
    logic        stall, outZero;
    logic [31:0] outBranchTarget, outAluResult, outRead2;
    logic [4:0]  outWriteReg;
    logic        outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, outJump;
    int nCmp = 0;
    int nFail = 0;

    typedef struct {
        bit          d;
        bit          st;
        logic [5:0]  ctl;
        logic [31:0] res;
        bit          z;
        logic [4:0]  wr;
        logic [31:0] bt;
        logic [31:0] r2;
    } exp_t;
    exp_t q[$];

    execute_stage #(.MULT_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .pcAdded(pcAdded), .read1(read1),
        .read2(read2), .imm(imm), .i20_16(i20_16), .i15_11(i15_11), .regDst(regDst),
        .aluSrc(aluSrc), .aluOp(aluOp), .branch(branch), .memWrite(memWrite),
        .memRead(memRead), .regWrite(regWrite), .memToReg(memToReg), .jump(jump),
        .stall(stall), .outBranchTarget(outBranchTarget), .outZero(outZero),
        .outAluResult(outAluResult), .outRead2(outRead2), .outWriteReg(outWriteReg),
        .outBranch(outBranch), .outMemWrite(outMemWrite), .outMemRead(outMemRead),
        .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .outJump(outJump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic op(input bit rst, input bit fl, input logic [2:0] ao, input bit as,
                      input bit rdst, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] ctl);
        @(negedge clk);
        reset = rst; flush = fl; aluOp = ao; aluSrc = as; regDst = rdst;
        read1 = a; read2 = b; imm = im; pcAdded = pc; i20_16 = rt; i15_11 = rd;
        {branch, memWrite, memRead, regWrite, memToReg, jump} = ctl;
    endtask

    task automatic ex(input bit d, input bit st, input logic [5:0] ctl, input logic [31:0] res,
                      input bit z, input logic [4:0] wr, input logic [31:0] bt,
                      input logic [31:0] r2);
        exp_t e;
        e.d = d; e.st = st; e.ctl = ctl; e.res = res; e.z = z; e.wr = wr; e.bt = bt; e.r2 = r2;
        q.push_back(e);
    endtask

    task automatic bubble(input bit st);
        ex(1'b0, st, 6'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // stall sampled just before the edge, EX/MEM just after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, e.st});
                @(posedge clk);
                #1;
                chk("ctl", {26'd0, outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, outJump},
                    {26'd0, e.ctl});
                if (e.d) begin
                    chk("aluResult", outAluResult, e.res);
                    chk("zero", {31'd0, outZero}, {31'd0, e.z});
                    chk("writeReg", {27'd0, outWriteReg}, {27'd0, e.wr});
                    chk("branchTarget", outBranchTarget, e.bt);
                    chk("read2", outRead2, e.r2);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            op(1'b1, $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, $urandom,
               5'($urandom), 5'($urandom), 6'($urandom));
            ex(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        end
        op(0, 0, 3'b000, 1, 0, 32'h10, 32'h55, 32'hFFFFFFFC, 32'h200, 5'd8, 5'd3, 6'b000100);
        ex(1, 0, 6'b000100, 32'hC, 0, 5'd8, 32'h1F0, 32'h55);
        op(0, 0, 3'b001, 0, 0, 32'd5, 32'd5, 32'd3, 32'h100, 5'd2, 5'd0, 6'b100000);
        ex(1, 0, 6'b100000, 32'd0, 1, 5'd2, 32'h10C, 32'd5);
        op(0, 0, 3'b101, 0, 1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h40, 5'd1, 5'd9, 6'b000100);
        ex(1, 0, 6'b000100, 32'd1, 0, 5'd9, 32'h40, 32'd1);
        op(0, 0, 3'b010, 0, 0, 32'd1, 32'hFFFFFFFF, 32'h2A, 32'h0, 5'd3, 5'd0, 6'b000100);
        ex(1, 0, 6'b000100, 32'd0, 1, 5'd3, 32'hA8, 32'hFFFFFFFF);
        op(0, 0, 3'b010, 0, 1, 32'hF0F0, 32'hFF00, 32'h24, 32'h0, 5'd0, 5'd5, 6'b000100);
        ex(1, 0, 6'b000100, 32'hF000, 0, 5'd5, 32'h90, 32'hFF00);
        op(0, 0, 3'b100, 1, 0, 32'hF0, 32'h1, 32'h0F, 32'h0, 5'd6, 5'd0, 6'b000100);
        ex(1, 0, 6'b000100, 32'hFF, 0, 5'd6, 32'h3C, 32'h1);
        op(0, 0, 3'b010, 0, 1, 32'd3, 32'd5, 32'h22, 32'h0, 5'd0, 5'd7, 6'b000100);
        ex(1, 0, 6'b000100, 32'hFFFFFFFE, 0, 5'd7, 32'h88, 32'd5);
        // MULT: 33 stalled bubble cycles then the product
        for (int i = 0; i < 34; i++) begin
            op(0, 0, 3'b010, 0, 1, 32'd7, 32'hFFFFFFFF, 32'h18, 32'h300, 5'd0, 5'd10, 6'b000100);
            if (i < 33) bubble(1);
            else ex(1, 0, 6'b000100, 32'hFFFFFFF9, 0, 5'd10, 32'h360, 32'hFFFFFFFF);
        end
        op(0, 0, 3'b110, 0, 0, 32'd2, 32'd3, 32'd0, 32'h4, 5'd1, 5'd0, 6'b001010);
        ex(1, 0, 6'b001010, 32'd5, 0, 5'd1, 32'h4, 32'd3);
        // flush at BUSY iteration 10
        for (int i = 0; i < 11; i++) begin
            op(0, 0, 3'b010, 0, 1, 32'd3, 32'd4, 32'h18, 32'h0, 5'd0, 5'd10, 6'b000100);
            bubble(1);
        end
        op(0, 1, 3'b010, 0, 1, 32'd3, 32'd4, 32'h18, 32'h0, 5'd0, 5'd10, 6'b000100);
        bubble(0);
        op(0, 0, 3'b000, 1, 0, 32'hFFFFFFFF, 32'h77, 32'd1, 32'h10, 5'd1, 5'd0, 6'b000100);
        ex(1, 0, 6'b000100, 32'd0, 1, 5'd1, 32'h14, 32'h77);
        // flush beats MULT start
        op(0, 1, 3'b010, 0, 1, 32'd3, 32'd4, 32'h18, 32'h0, 5'd0, 5'd10, 6'b000100);
        bubble(0);
        op(0, 0, 3'b110, 0, 0, 32'd2, 32'd3, 32'd0, 32'h4, 5'd1, 5'd0, 6'b000100);
        ex(1, 0, 6'b000100, 32'd5, 0, 5'd1, 32'h4, 32'd3);
        // reset mid-MULT discards the partial product
        for (int i = 0; i < 4; i++) begin
            op(0, 0, 3'b010, 0, 1, 32'd9, 32'd9, 32'h18, 32'h0, 5'd0, 5'd10, 6'b000100);
            bubble(1);
        end
        op(1, 1, 3'b010, 0, 1, 32'd9, 32'd9, 32'h18, 32'h0, 5'd0, 5'd10, 6'b000100);
        ex(1, 0, 6'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
        op(0, 0, 3'b010, 0, 1, 32'd5, 32'd6, 32'h07, 32'h20, 5'd0, 5'd4, 6'b010011);
        ex(1, 0, 6'b010011, 32'd0, 1, 5'd4, 32'h3C, 32'd6);
        op(0, 0, 3'b000, 0, 0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 6'd0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end
endmodule
